multicycle_sequencer: RTL
=========================

# multicycle_sequencer

Multi-cycle instruction sequencer for the RISC-V core. It steps each instruction through fetch, decode, execute, memory and writeback, and waits on instruction-memory and data-memory ready handshakes. The decode outputs of the control unit are used as level signals, and the sequencer turns them into single-cycle commit strobes (instruction register, PC, register file, data memory). It sits between the combinational control unit and the shared datapath/memory ports. It also counts retired instructions and traps to a sticky fault state on memory timeout.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction width
- CNT_WIDTH, 32, retired-instruction counter width
- MEM_TIMEOUT, 15, maximum wait cycles per memory request; 0 disables timeout

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- instr_i  in  DATA_WIDTH  instruction register contents, valid from DECODE onward
- RegWrite_i  in  3  control-unit register-write code; nonzero means the instruction writes rd
- imem_ready_i  in  1  instruction memory data valid this cycle
- dmem_ready_i  in  1  data memory access complete this cycle
- imem_req_o  out  1  instruction fetch request
- IRWrite_o  out  1  latch fetched instruction into IR
- dmem_req_o  out  1  data memory request
- dmem_we_o  out  1  data memory request is a store
- RegWriteEn_o  out  1  register-file write enable (gates RegWrite_i)
- PCWrite_o  out  1  commit next PC (selected by datapath via PCsrc)
- fault_o  out  1  sticky memory-timeout fault
- state_o  out  3  current state encoding
- retired_o  out  CNT_WIDTH  retired-instruction count

## Operation
- Class decode uses instr_i[6:0]: load = 7'b0000011, store = 7'b0100011. All other opcodes are non-memory.
- States and encodings: FETCH 3'b000, DECODE 3'b001, EXECUTE 3'b010, MEMORY 3'b011, WRITEBACK 3'b100, FAULT 3'b111.
- FETCH: imem_req_o=1.
  - If imem_ready_i: IRWrite_o=1 that cycle; next state DECODE.
- DECODE: one cycle, no strobes; next state EXECUTE. Control-unit outputs settle here.
- EXECUTE: one cycle.
  - Load or store: next state MEMORY.
  - Else if RegWrite_i≠0: next state WRITEBACK.
  - Else: PCWrite_o=1, retire; next state FETCH.
- MEMORY: dmem_req_o=1; dmem_we_o=1 for store.
  - On dmem_ready_i, store: PCWrite_o=1, retire; next state FETCH.
  - On dmem_ready_i, load: next state WRITEBACK.
- WRITEBACK: RegWriteEn_o=1, PCWrite_o=1, retire; next state FETCH.
- FAULT: all strobes and requests 0, fault_o=1. Exit only by rst.
- Retire: retired_o increments by 1 on the following edge. It wraps modulo 2^CNT_WIDTH with no flag.
- Wait timer: wait_cnt is cleared on entry to FETCH/MEMORY and whenever ready is seen. It increments each FETCH/MEMORY cycle without ready.
  - With MEM_TIMEOUT>0, if wait_cnt==MEM_TIMEOUT and ready is low: next state FAULT.
  - If ready is high in that same cycle, ready wins and normal progress continues.
  - A request is therefore held at most MEM_TIMEOUT+1 cycles.
- Ready inputs are ignored outside their owning state.

## Timing
- Moore outputs (from state register): imem_req_o, dmem_req_o, dmem_we_o, RegWriteEn_o, fault_o, state_o.
- Mealy outputs: IRWrite_o (FETCH & imem_ready_i) and PCWrite_o (as listed above).
- Cycles per instruction with zero-wait memory (ready in the first request cycle):
  - branch/JAL-free non-writing: 3
  - R/I-type, JAL, LUI: 4
  - store: 4
  - load: 5
- Each memory wait cycle adds 1.
- Reset values, applied asynchronously mid-instruction: state FETCH, wait_cnt 0, retired_o 0, fault_o 0, all strobes 0. imem_req_o is 1 once rst deasserts.
- An in-flight memory request is abandoned on reset; no PC/register commit occurs.

## Structure
- Shared package ctrl_pkg holds:
  - typedef enum logic [2:0] seq_state_t with the encodings above
  - constants OPC_LOAD and OPC_STORE
- Sub-module mem_wait_timer (parameter MEM_TIMEOUT) provides:
  - inputs: clk, rst, clear, tick
  - output: expired
- The sequencer holds the FSM, strobe decode and retire counter.

## Test plan
- Zero-wait ADD (0x002081B3, RegWrite_i=001), ready tied high:
  - states 000→001→010→100→000
  - RegWriteEn_o and PCWrite_o high together in one cycle
  - retired_o 0→1
- LW (0x0000A183) with dmem_ready_i after 3 cycles:
  - dmem_req_o high for 4 cycles, dmem_we_o=0
  - WRITEBACK follows; total 8 cycles
- SW (0x0030A023), RegWrite_i=000:
  - dmem_we_o=1 in MEMORY; PCWrite_o on the ready cycle
  - RegWriteEn_o never asserted
- BEQ (0x00208463), RegWrite_i=000:
  - PCWrite_o in EXECUTE, 3-cycle instruction, no memory request
- Timeout: MEM_TIMEOUT=15, imem_ready_i held low:
  - FAULT entered after 16 request cycles; fault_o stays 1
  - repeat with ready arriving exactly on cycle 16: no fault
- Reset mid-MEMORY, then wrap:
  - rst asserted mid-cycle returns state_o=000 immediately and clears retired_o
  - with CNT_WIDTH=4, 16 retirements wrap retired_o to 0

Source files
------------

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared state encodings and opcode classes for the multicycle sequencer
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'b000,
        ST_DECODE    = 3'b001,
        ST_EXECUTE   = 3'b010,
        ST_MEMORY    = 3'b011,
        ST_WRITEBACK = 3'b100,
        ST_FAULT     = 3'b111
    } seq_state_t;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    function automatic logic is_mem_opcode(input logic [6:0] opc);
        return (opc == OPC_LOAD) || (opc == OPC_STORE);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts unanswered memory-request cycles and flags the timeout limit
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TIMEOUT_VAL = CW'(MEM_TIMEOUT);

    logic [CW-1:0] wait_cnt_q;
    logic [CW-1:0] wait_cnt_d;

    // A limit of zero never expires; the counter then simply free-runs while waiting.
    assign expired = (MEM_TIMEOUT != 0) && (wait_cnt_q == TIMEOUT_VAL);

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (clear) begin
            wait_cnt_d = '0;
        end else if (tick && !expired) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - fetch/decode/execute/memory/writeback sequencer with commit strobes,
// retire counter and sticky memory-timeout fault
module multicycle_sequencer
    import ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int CNT_WIDTH   = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] instr_i,
    input  logic [2:0]            RegWrite_i,
    input  logic                  imem_ready_i,
    input  logic                  dmem_ready_i,
    output logic                  imem_req_o,
    output logic                  IRWrite_o,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic                  RegWriteEn_o,
    output logic                  PCWrite_o,
    output logic                  fault_o,
    output logic [2:0]            state_o,
    output logic [CNT_WIDTH-1:0]  retired_o
);

    seq_state_t           state_q, state_d;
    logic                 is_store_q, is_store_d;
    logic [CNT_WIDTH-1:0] retired_q, retired_d;

    logic       ir_write;
    logic       pc_write;
    logic       timer_tick;
    logic       timer_clear;
    logic       timer_expired;
    logic [6:0] opcode;
    logic       unused_instr;

    assign opcode       = instr_i[6:0];
    assign unused_instr = ^instr_i[DATA_WIDTH-1:7];

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .tick    (timer_tick),
        .expired (timer_expired)
    );

    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        timer_tick = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (imem_ready_i) begin
                    ir_write = 1'b1;
                    state_d  = ST_DECODE;
                end else begin
                    timer_tick = 1'b1;
                    if (timer_expired) begin
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_DECODE: begin
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                // Latch the class so the memory phase does not depend on instr_i staying put.
                is_store_d = (opcode == OPC_STORE);
                if (is_mem_opcode(opcode)) begin
                    state_d = ST_MEMORY;
                end else if (RegWrite_i != 3'b000) begin
                    state_d = ST_WRITEBACK;
                end else begin
                    pc_write = 1'b1;
                    state_d  = ST_FETCH;
                end
            end
            ST_MEMORY: begin
                if (dmem_ready_i) begin
                    if (is_store_q) begin
                        pc_write = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        state_d = ST_WRITEBACK;
                    end
                end else begin
                    timer_tick = 1'b1;
                    if (timer_expired) begin
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_WRITEBACK: begin
                pc_write = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
        timer_clear = !timer_tick;
        retired_d   = retired_q + CNT_WIDTH'(pc_write);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            is_store_q <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            retired_q  <= retired_d;
        end
    end

    // Everything is held quiet while reset is asserted, including the Mealy strobes.
    assign imem_req_o   = !rst && (state_q == ST_FETCH);
    assign IRWrite_o    = !rst && ir_write;
    assign dmem_req_o   = !rst && (state_q == ST_MEMORY);
    assign dmem_we_o    = !rst && (state_q == ST_MEMORY) && is_store_q;
    assign RegWriteEn_o = !rst && (state_q == ST_WRITEBACK);
    assign PCWrite_o    = !rst && pc_write;
    assign fault_o      = (state_q == ST_FAULT);
    assign state_o      = state_q;
    assign retired_o    = retired_q;

endmodule
